// File: rtl/siFH_pkg.sv
// Shared sizing and types for the SiFH peak readout path.
// The defaults mirror the values used in parametersSiFH.vh.
package siFH_pkg;

    localparam int SIFH_NP        = 16;
    localparam int SIFH_PIXEL_NUM = 8;
    localparam int PIX_W          = $clog2(SIFH_PIXEL_NUM);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } stream_state_e;

    typedef logic [SIFH_NP*SIFH_PIXEL_NUM-1:0] peak_vec_t;

endpackage

// File: rtl/peak_snapshot_buf.sv
// Two-entry snapshot store: an active vector being streamed and one pending
// vector queued behind it, each tagged with its frame id.
module peak_snapshot_buf
    import siFH_pkg::*;
#(
    parameter int NP        = SIFH_NP,
    parameter int PIXEL_NUM = SIFH_PIXEL_NUM,
    parameter int FRAME_W   = 16
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic [NP*PIXEL_NUM-1:0] peak_i,
    input  logic [FRAME_W-1:0]      frame_id_i,
    input  logic                    load_act_i,
    input  logic                    load_pend_i,
    input  logic                    promote_i,
    input  logic                    retire_i,
    output logic [NP*PIXEL_NUM-1:0] act_peak_o,
    output logic [FRAME_W-1:0]      act_frame_o,
    output logic                    act_vld_o,
    output logic                    pend_vld_o
);

    logic [NP*PIXEL_NUM-1:0] act_peak_q, act_peak_d;
    logic [NP*PIXEL_NUM-1:0] pend_peak_q, pend_peak_d;
    logic [FRAME_W-1:0]      act_frame_q, act_frame_d;
    logic [FRAME_W-1:0]      pend_frame_q, pend_frame_d;
    logic                    act_vld_q, act_vld_d;
    logic                    pend_vld_q, pend_vld_d;

    // A promote and a pending load may coincide: active takes the old
    // pending entry while pending takes the incoming frame.
    always_comb begin
        act_peak_d   = act_peak_q;
        act_frame_d  = act_frame_q;
        act_vld_d    = act_vld_q;
        pend_peak_d  = pend_peak_q;
        pend_frame_d = pend_frame_q;
        pend_vld_d   = pend_vld_q;

        if (load_act_i) begin
            act_peak_d  = peak_i;
            act_frame_d = frame_id_i;
            act_vld_d   = 1'b1;
        end else if (promote_i) begin
            act_peak_d  = pend_peak_q;
            act_frame_d = pend_frame_q;
            act_vld_d   = 1'b1;
        end else if (retire_i) begin
            act_vld_d   = 1'b0;
        end

        if (load_pend_i) begin
            pend_peak_d  = peak_i;
            pend_frame_d = frame_id_i;
            pend_vld_d   = 1'b1;
        end else if (promote_i) begin
            pend_vld_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            act_peak_q   <= '0;
            act_frame_q  <= '0;
            act_vld_q    <= 1'b0;
            pend_peak_q  <= '0;
            pend_frame_q <= '0;
            pend_vld_q   <= 1'b0;
        end else begin
            act_peak_q   <= act_peak_d;
            act_frame_q  <= act_frame_d;
            act_vld_q    <= act_vld_d;
            pend_peak_q  <= pend_peak_d;
            pend_frame_q <= pend_frame_d;
            pend_vld_q   <= pend_vld_d;
        end
    end

    assign act_peak_o  = act_peak_q;
    assign act_frame_o = act_frame_q;
    assign act_vld_o   = act_vld_q;
    assign pend_vld_o  = pend_vld_q;

endmodule

// File: rtl/peak_result_streamer.sv
// Captures the per-pixel peak vector at frame completion and streams it one
// pixel per valid/ready transfer, queuing one frame and counting drops.
module peak_result_streamer
    import siFH_pkg::*;
#(
    parameter int NP        = SIFH_NP,
    parameter int PIXEL_NUM = SIFH_PIXEL_NUM,
    parameter int FRAME_W   = 16,
    parameter int DROP_W    = 8
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic                         frame_done,
    input  logic [NP*PIXEL_NUM-1:0]      peak_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NP-1:0]                out_data,
    output logic [$clog2(PIXEL_NUM)-1:0] out_pixel,
    output logic                         out_last,
    output logic [FRAME_W-1:0]           out_frame,
    output logic                         busy,
    output logic                         overrun,
    output logic [DROP_W-1:0]            drop_cnt,
    input  logic                         clr_overrun
);

    localparam int PIX_BITS = $clog2(PIXEL_NUM);
    localparam logic [PIX_BITS-1:0] LAST_PIX = PIX_BITS'(PIXEL_NUM - 1);

    stream_state_e           state_q, state_d;
    logic [PIX_BITS-1:0]     pix_q, pix_d;
    logic [FRAME_W-1:0]      frame_cnt_q, frame_cnt_d;
    logic [DROP_W-1:0]       drop_cnt_q, drop_cnt_d, drop_base;
    logic                    overrun_q, overrun_d;

    logic [NP*PIXEL_NUM-1:0] act_peak;
    logic                    act_vld;
    logic                    pend_vld;
    logic                    xfer;
    logic                    last_xfer;
    logic                    load_act;
    logic                    load_pend;
    logic                    promote;
    logic                    retire;
    logic                    drop;

    // Buffer steering: a finishing frame frees the active slot in the same
    // cycle, so a frame arriving then is never dropped.
    always_comb begin
        xfer      = out_valid && out_ready;
        last_xfer = xfer && out_last;
        promote   = last_xfer && pend_vld;
        retire    = last_xfer && !pend_vld && !frame_done;
        load_act  = frame_done && ((state_q == IDLE) || (last_xfer && !pend_vld));
        load_pend = frame_done && (state_q == DRAIN)
                    && ((!pend_vld && !last_xfer) || (pend_vld && last_xfer));
        drop      = frame_done && (state_q == DRAIN) && pend_vld && !last_xfer;
    end

    peak_snapshot_buf #(
        .NP        (NP),
        .PIXEL_NUM (PIXEL_NUM),
        .FRAME_W   (FRAME_W)
    ) u_buf (
        .clk         (clk),
        .res         (res),
        .peak_i      (peak_in),
        .frame_id_i  (frame_cnt_q),
        .load_act_i  (load_act),
        .load_pend_i (load_pend),
        .promote_i   (promote),
        .retire_i    (retire),
        .act_peak_o  (act_peak),
        .act_frame_o (out_frame),
        .act_vld_o   (act_vld),
        .pend_vld_o  (pend_vld)
    );

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_done) state_d = DRAIN;
            DRAIN:   if (retire)     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == DRAIN);
        out_last  = out_valid && (pix_q == LAST_PIX);
        busy      = act_vld || pend_vld;
    end

    always_comb begin
        out_data = '0;
        for (int p = 0; p < PIXEL_NUM; p++) begin
            if (pix_q == PIX_BITS'(p)) begin
                out_data = act_peak[p*NP +: NP];
            end
        end
    end

    assign out_pixel = pix_q;
    assign overrun   = overrun_q;
    assign drop_cnt  = drop_cnt_q;

    // A drop in the same cycle as a clear still registers as one drop.
    always_comb begin
        pix_d       = pix_q;
        frame_cnt_d = frame_cnt_q;
        drop_base   = clr_overrun ? '0 : drop_cnt_q;
        drop_cnt_d  = drop_base;
        overrun_d   = clr_overrun ? 1'b0 : overrun_q;

        if (xfer) begin
            pix_d = out_last ? '0 : pix_q + PIX_BITS'(1);
        end
        if (frame_done) begin
            frame_cnt_d = frame_cnt_q + FRAME_W'(1);
        end
        if (drop) begin
            overrun_d = 1'b1;
            if (drop_base != '1) begin
                drop_cnt_d = drop_base + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            pix_q       <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            pix_q       <= pix_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            overrun_q   <= overrun_d;
        end
    end

endmodule

// File: tb/tb_peak_result_streamer.sv
// Directed bench for peak_result_streamer: single frame, backpressure,
// back-to-back frames, overrun, coincident events and mid-stream reset.
module tb_peak_result_streamer;

    localparam int NP        = 16;
    localparam int PIXEL_NUM = 8;
    localparam int FRAME_W   = 16;
    localparam int DROP_W    = 8;

    logic                    clk;
    logic                    res;
    logic                    frame_done;
    logic [NP*PIXEL_NUM-1:0] peak_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [NP-1:0]           out_data;
    logic [2:0]              out_pixel;
    logic                    out_last;
    logic [FRAME_W-1:0]      out_frame;
    logic                    busy;
    logic                    overrun;
    logic [DROP_W-1:0]       drop_cnt;
    logic                    clr_overrun;

    int assertCount;
    int failCount;

    peak_result_streamer #(
        .NP        (NP),
        .PIXEL_NUM (PIXEL_NUM),
        .FRAME_W   (FRAME_W),
        .DROP_W    (DROP_W)
    ) dut (
        .clk         (clk),
        .res         (res),
        .frame_done  (frame_done),
        .peak_in     (peak_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_pixel   (out_pixel),
        .out_last    (out_last),
        .out_frame   (out_frame),
        .busy        (busy),
        .overrun     (overrun),
        .drop_cnt    (drop_cnt),
        .clr_overrun (clr_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NP*PIXEL_NUM-1:0] mkVec(input logic [15:0] base);
        logic [NP*PIXEL_NUM-1:0] v;
        for (int p = 0; p < PIXEL_NUM; p++) v[p*NP +: NP] = base + 16'(p);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic fd, input logic [15:0] base, input logic rdy);
        frame_done = fd;
        peak_in    = mkVec(base);
        out_ready  = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkWord(input string tag, input int pix, input logic [15:0] base, input int frm);
        checkOutput({tag, " valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, " pixel"}, 32'(out_pixel), 32'(pix));
        checkOutput({tag, " data"},  32'(out_data),  32'(base + 16'(pix)));
        checkOutput({tag, " last"},  32'(out_last),  32'(pix == PIXEL_NUM - 1));
        checkOutput({tag, " frame"}, 32'(out_frame), 32'(frm));
    endtask

    initial begin
        int idx;
        int cyc;
        assertCount = 0;
        failCount   = 0;
        res         = 1'b0;
        clr_overrun = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk) res = 1'b1;
        tick();

        $display("[TB] reset state");
        checkOutput("rst valid", 32'(out_valid), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst overrun", 32'(overrun), 32'd0);
        checkOutput("rst drop_cnt", 32'(drop_cnt), 32'd0);
        checkOutput("rst data", 32'(out_data), 32'd0);
        checkOutput("rst pixel", 32'(out_pixel), 32'd0);
        checkOutput("rst frame", 32'(out_frame), 32'd0);
        checkOutput("rst last", 32'(out_last), 32'd0);

        $display("[TB] single frame, ready high");
        applyStimulus(1'b1, 16'h0010, 1'b1);
        tick();
        frame_done = 1'b0;
        for (int k = 0; k < PIXEL_NUM; k++) begin
            checkWord("single", k, 16'h0010, 0);
            tick();
        end
        checkOutput("single idle valid", 32'(out_valid), 32'd0);
        checkOutput("single idle busy", 32'(busy), 32'd0);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 16'h0020, 1'b0);
        tick();
        frame_done = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < PIXEL_NUM && cyc < 64) begin
            out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            checkWord("bp", idx, 16'h0020, 1);
            if (out_ready) idx++;
            tick();
            cyc++;
        end
        checkOutput("bp words delivered", 32'(idx), 32'(PIXEL_NUM));
        checkOutput("bp idle valid", 32'(out_valid), 32'd0);

        $display("[TB] back-to-back frames");
        applyStimulus(1'b1, 16'h0030, 1'b1);
        tick();
        for (int i = 0; i < 2 * PIXEL_NUM; i++) begin
            frame_done = (i == 3);
            peak_in    = mkVec(16'h0040);
            if (i < PIXEL_NUM) checkWord("b2b f2", i, 16'h0030, 2);
            else               checkWord("b2b f3", i - PIXEL_NUM, 16'h0040, 3);
            if (i == 5) checkOutput("b2b busy", 32'(busy), 32'd1);
            tick();
        end
        frame_done = 1'b0;
        checkOutput("b2b idle valid", 32'(out_valid), 32'd0);
        checkOutput("b2b idle busy", 32'(busy), 32'd0);

        $display("[TB] overrun");
        applyStimulus(1'b1, 16'h0050, 1'b0);
        tick();
        applyStimulus(1'b1, 16'h0060, 1'b0);
        tick();
        applyStimulus(1'b1, 16'h0070, 1'b0);
        tick();
        frame_done = 1'b0;
        checkOutput("ovr overrun", 32'(overrun), 32'd1);
        checkOutput("ovr drop_cnt", 32'(drop_cnt), 32'd1);
        checkWord("ovr held", 0, 16'h0050, 4);
        out_ready = 1'b1;
        for (int i = 0; i < 2 * PIXEL_NUM; i++) begin
            if (i < PIXEL_NUM) checkWord("ovr f4", i, 16'h0050, 4);
            else               checkWord("ovr f5", i - PIXEL_NUM, 16'h0060, 5);
            tick();
        end
        checkOutput("ovr no f6 valid", 32'(out_valid), 32'd0);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        checkOutput("clr overrun", 32'(overrun), 32'd0);
        checkOutput("clr drop_cnt", 32'(drop_cnt), 32'd0);

        $display("[TB] last transfer + frame_done, pending full");
        applyStimulus(1'b1, 16'h0080, 1'b0);
        tick();
        applyStimulus(1'b1, 16'h0090, 1'b0);
        tick();
        frame_done = 1'b0;
        out_ready  = 1'b1;
        for (int i = 0; i < 3 * PIXEL_NUM; i++) begin
            frame_done = (i == PIXEL_NUM - 1);
            peak_in    = mkVec(16'h00A0);
            if (i < PIXEL_NUM)          checkWord("sim f7", i, 16'h0080, 7);
            else if (i < 2 * PIXEL_NUM) checkWord("sim f8", i - PIXEL_NUM, 16'h0090, 8);
            else                        checkWord("sim f9", i - 2 * PIXEL_NUM, 16'h00A0, 9);
            tick();
        end
        frame_done = 1'b0;
        checkOutput("sim no drop overrun", 32'(overrun), 32'd0);
        checkOutput("sim no drop cnt", 32'(drop_cnt), 32'd0);
        checkOutput("sim idle valid", 32'(out_valid), 32'd0);

        $display("[TB] last transfer + frame_done, pending empty");
        applyStimulus(1'b1, 16'h00B0, 1'b1);
        tick();
        for (int i = 0; i < 2 * PIXEL_NUM; i++) begin
            frame_done = (i == PIXEL_NUM - 1);
            peak_in    = mkVec(16'h00C0);
            if (i < PIXEL_NUM) checkWord("direct f10", i, 16'h00B0, 10);
            else               checkWord("direct f11", i - PIXEL_NUM, 16'h00C0, 11);
            tick();
        end
        frame_done = 1'b0;
        checkOutput("direct idle valid", 32'(out_valid), 32'd0);
        checkOutput("direct idle busy", 32'(busy), 32'd0);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 16'h00D0, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            frame_done = (i == 0);
            peak_in    = mkVec(16'h00E0);
            checkWord("rst f12", i, 16'h00D0, 12);
            if (i < 4) tick();
        end
        frame_done = 1'b0;
        checkOutput("rst busy before", 32'(busy), 32'd1);
        res = 1'b0;
        #1;
        checkOutput("async valid", 32'(out_valid), 32'd0);
        checkOutput("async busy", 32'(busy), 32'd0);
        checkOutput("async pixel", 32'(out_pixel), 32'd0);
        @(negedge clk) res = 1'b1;
        tick();
        applyStimulus(1'b1, 16'h00F0, 1'b1);
        tick();
        frame_done = 1'b0;
        for (int k = 0; k < PIXEL_NUM; k++) begin
            checkWord("post rst f0", k, 16'h00F0, 0);
            tick();
        end
        checkOutput("post rst idle valid", 32'(out_valid), 32'd0);
        checkOutput("post rst idle busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
